// File: rtl/bcd_updown_cnt.sv
// Parametrised multi-digit BCD up/down counter with enable, parallel load,
// selectable wrap/saturate at the limits and a combinational terminal count
// for cascading several instances.
module bcd_updown_cnt #(
   parameter int unsigned DIGITS = 3,
   parameter int unsigned WRAP   = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   input  logic                dir,
   input  logic                load,
   input  logic [4*DIGITS-1:0] din,
   output logic [4*DIGITS-1:0] cnt,
   output logic                tc,
   output logic                zero
);

   localparam int unsigned W   = 4 * DIGITS;
   localparam bit          SAT = (WRAP == 0);

   logic [W-1:0] cnt_q, cnt_d;
   logic [W-1:0] din_clamped;
   logic [W-1:0] up_val, dn_val;
   logic [3:0]   dig;
   logic         up_c, dn_b;
   logic         at_max, at_min;

   // Clamp each load digit into BCD range so cnt never holds a digit above 9.
   always_comb begin
      din_clamped = '0;
      for (int i = 0; i < DIGITS; i++) begin
         din_clamped[4*i +: 4] = (din[4*i +: 4] > 4'd9) ? 4'd9 : din[4*i +: 4];
      end
   end

   // Detect the all-nines upper limit.
   always_comb begin
      at_max = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (cnt_q[4*i +: 4] != 4'd9) at_max = 1'b0;
      end
   end

   assign at_min = (cnt_q == '0);

   // Ripple carry/borrow across digits to form the incremented and decremented values.
   always_comb begin
      up_val = cnt_q;
      dn_val = cnt_q;
      up_c   = 1'b1;
      dn_b   = 1'b1;
      dig    = 4'd0;
      for (int i = 0; i < DIGITS; i++) begin
         dig = cnt_q[4*i +: 4];
         if (up_c) begin
            if (dig == 4'd9) begin
               up_val[4*i +: 4] = 4'd0;
            end else begin
               up_val[4*i +: 4] = dig + 4'd1;
               up_c             = 1'b0;
            end
         end
         if (dn_b) begin
            if (dig == 4'd0) begin
               dn_val[4*i +: 4] = 4'd9;
            end else begin
               dn_val[4*i +: 4] = dig - 4'd1;
               dn_b             = 1'b0;
            end
         end
      end
   end

   // Next count: load beats a step; saturating builds hold at the limit.
   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = din_clamped;
      end else if (en) begin
         if (dir) begin
            if (!(SAT && at_max)) cnt_d = up_val;
         end else begin
            if (!(SAT && at_min)) cnt_d = dn_val;
         end
      end
   end

   // Count register with synchronous reset taking priority over load and step.
   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign cnt  = cnt_q;
   assign zero = at_min;
   assign tc   = en & ~load & ~rst & ((dir & at_max) | (~dir & at_min));

endmodule

// File: tb/tb_bcd_updown_cnt.sv
// Scoreboard bench for bcd_updown_cnt: a wrapping 3-digit counter, a saturating
// 3-digit counter and a cascaded pair of 1-digit counters share one stimulus
// stream and are compared against integer-valued reference models.
module tb_bcd_updown_cnt;

   logic        clk;
   logic        rst, en, dir, load;
   logic [11:0] din;
   logic [11:0] cnt3, cnt3s;
   logic        tc3, zero3, tc3s, zero3s;
   logic [3:0]  cnt_lo, cnt_hi;
   logic        tc_lo, tc_hi, zero_lo, zero_hi;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [11:0] c3;
      logic [11:0] c3s;
      logic [7:0]  c2;
   } post_t;

   typedef struct {
      bit t3, z3, t3s, z3s, t2, z2;
   } pre_t;

   post_t post_q[$];
   pre_t  pre_q[$];

   int m3, m3s, m2;

   bcd_updown_cnt #(.DIGITS(3), .WRAP(1)) u_wrap (
      .clk(clk), .rst(rst), .en(en), .dir(dir), .load(load), .din(din),
      .cnt(cnt3), .tc(tc3), .zero(zero3)
   );

   bcd_updown_cnt #(.DIGITS(3), .WRAP(0)) u_sat (
      .clk(clk), .rst(rst), .en(en), .dir(dir), .load(load), .din(din),
      .cnt(cnt3s), .tc(tc3s), .zero(zero3s)
   );

   bcd_updown_cnt #(.DIGITS(1), .WRAP(1)) u_lo (
      .clk(clk), .rst(rst), .en(en), .dir(dir), .load(load), .din(din[3:0]),
      .cnt(cnt_lo), .tc(tc_lo), .zero(zero_lo)
   );

   bcd_updown_cnt #(.DIGITS(1), .WRAP(1)) u_hi (
      .clk(clk), .rst(rst), .en(tc_lo), .dir(dir), .load(load), .din(din[7:4]),
      .cnt(cnt_hi), .tc(tc_hi), .zero(zero_hi)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Decimal value -> packed BCD.
   function automatic logic [31:0] to_bcd(input int v);
      logic [31:0] r;
      int          x;
      r = '0;
      x = v;
      for (int i = 0; i < 8; i++) begin
         r[4*i +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   // Decimal value of a load word with each digit clamped to 9.
   function automatic int load_val(input logic [11:0] d, input int nd);
      int v, mul, dg;
      v   = 0;
      mul = 1;
      for (int i = 0; i < nd; i++) begin
         dg = int'(d[4*i +: 4]);
         if (dg > 9) dg = 9;
         v   = v + dg * mul;
         mul = mul * 10;
      end
      return v;
   endfunction

   function automatic int step(input int v, input bit up, input int maxv, input bit wrap);
      if (up) return (v == maxv) ? (wrap ? 0 : maxv) : v + 1;
      else    return (v == 0)    ? (wrap ? maxv : 0) : v - 1;
   endfunction

   function automatic bit tc_model(input int v, input int maxv, input bit r, input bit l,
                                   input bit e, input bit dr);
      return e && !l && !r && ((dr && v == maxv) || (!dr && v == 0));
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive one cycle of stimulus and queue the expected responses.
   task automatic cycle(input bit r, input bit l, input bit e, input bit dr, input logic [11:0] d);
      pre_t  pr;
      post_t po;
      @(negedge clk);
      rst = r; load = l; en = e; dir = dr; din = d;
      pr.t3  = tc_model(m3, 999, r, l, e, dr);
      pr.z3  = (m3 == 0);
      pr.t3s = tc_model(m3s, 999, r, l, e, dr);
      pr.z3s = (m3s == 0);
      pr.t2  = tc_model(m2, 99, r, l, e, dr);
      pr.z2  = (m2 == 0);
      pre_q.push_back(pr);
      if (r) begin
         m3 = 0; m3s = 0; m2 = 0;
      end else if (l) begin
         m3  = load_val(d, 3);
         m3s = load_val(d, 3);
         m2  = load_val(d, 2);
      end else if (e) begin
         m3  = step(m3, dr, 999, 1'b1);
         m3s = step(m3s, dr, 999, 1'b0);
         m2  = step(m2, dr, 99, 1'b1);
      end
      po.c3  = 12'(to_bcd(m3));
      po.c3s = 12'(to_bcd(m3s));
      po.c2  = 8'(to_bcd(m2));
      post_q.push_back(po);
   endtask

   // Registered count checked just after each rising edge.
   initial begin
      post_t p;
      forever begin
         @(posedge clk);
         #1;
         if (post_q.size() != 0) begin
            p = post_q.pop_front();
            check("cnt_wrap", 32'(cnt3), 32'(p.c3));
            check("cnt_sat", 32'(cnt3s), 32'(p.c3s));
            check("cnt_cascade", 32'({cnt_hi, cnt_lo}), 32'(p.c2));
         end
      end
   end

   // Combinational tc/zero checked mid-cycle, after inputs settle.
   initial begin
      pre_t p;
      forever begin
         @(negedge clk);
         #2;
         if (pre_q.size() != 0) begin
            p = pre_q.pop_front();
            check("tc_wrap", 32'(tc3), 32'(p.t3));
            check("zero_wrap", 32'(zero3), 32'(p.z3));
            check("tc_sat", 32'(tc3s), 32'(p.t3s));
            check("zero_sat", 32'(zero3s), 32'(p.z3s));
            check("tc_cascade", 32'(tc_hi), 32'(p.t2));
            check("zero_cascade", 32'(zero_lo & zero_hi), 32'(p.z2));
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int          sel;
      logic [11:0] rd;
      rst = 1'b1; en = 1'b0; dir = 1'b0; load = 1'b0; din = '0;
      m3 = 0; m3s = 0; m2 = 0;

      // Reset, then a full upward sweep through 999 and back to 000.
      repeat (2) cycle(1'b1, 1'b0, 1'b0, 1'b0, 12'h000);
      repeat (1000) cycle(1'b0, 1'b0, 1'b1, 1'b1, 12'h000);

      // Carry across digits: 099 -> 100, cascade 09 -> 10.
      cycle(1'b0, 1'b1, 1'b0, 1'b1, 12'h099);
      repeat (4) cycle(1'b0, 1'b0, 1'b1, 1'b1, 12'h000);
      cycle(1'b0, 1'b1, 1'b0, 1'b1, 12'h009);
      cycle(1'b0, 1'b0, 1'b1, 1'b1, 12'h000);

      // Down through zero: wrap to 999/998, saturate at 000.
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 12'h000);
      repeat (3) cycle(1'b0, 1'b0, 1'b1, 1'b0, 12'h000);

      // Invalid BCD load is clamped per digit.
      cycle(1'b0, 1'b1, 1'b1, 1'b1, 12'hA3F);
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 12'h000);

      // Reset wins over load and enable, then idle.
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 12'h555);
      cycle(1'b1, 1'b1, 1'b1, 1'b1, 12'h555);
      repeat (5) cycle(1'b0, 1'b0, 1'b0, 1'b1, 12'h000);

      // Up at the limit for all instances.
      cycle(1'b0, 1'b1, 1'b0, 1'b1, 12'h999);
      repeat (3) cycle(1'b0, 1'b0, 1'b1, 1'b1, 12'h000);

      // Randomized traffic biased toward the limits.
      repeat (2000) begin
         sel = int'($urandom_range(0, 3));
         if (sel == 0)      rd = 12'h999;
         else if (sel == 1) rd = 12'h000;
         else               rd = 12'($urandom);
         cycle(($urandom_range(0, 63) == 0), ($urandom_range(0, 15) == 0),
               ($urandom_range(0, 3) != 0), 1'($urandom), rd);
      end

      repeat (2) cycle(1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
      @(posedge clk);
      #3;
      check("scoreboard_drain", 32'(post_q.size() + pre_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
